// File: rtl/bc_dm_bridge_if.sv
// Signal bundle between the bus-connect bridge, the PS/CU pair and data memory.
// The bridge itself uses the master view; the surrounding system uses the slave view.
interface bc_dm_bridge_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int DM_ADDR_WIDTH = 16
);
    logic                     ps_bc_rd;
    logic                     ps_bc_wr;
    logic                     ps_bc_imm;
    logic [DM_ADDR_WIDTH-1:0] ps_bc_addr;
    logic [DATA_WIDTH-1:0]    ps_bc_imm_dt;
    logic                     ps_bc_err_clr;
    logic [DATA_WIDTH-1:0]    xb_dtx;
    logic [DATA_WIDTH-1:0]    bc_dt;
    logic                     bc_dt_vld;
    logic                     stallb;
    logic                     bc_ps_err;
    logic                     bc_dm_req;
    logic                     bc_dm_we;
    logic [DM_ADDR_WIDTH-1:0] bc_dm_addr;
    logic [DATA_WIDTH-1:0]    bc_dm_wdt;
    logic                     dm_bc_ack;
    logic [DATA_WIDTH-1:0]    dm_bc_rdt;

    modport master (
        input  ps_bc_rd, ps_bc_wr, ps_bc_imm, ps_bc_addr, ps_bc_imm_dt, ps_bc_err_clr,
        input  xb_dtx, dm_bc_ack, dm_bc_rdt,
        output bc_dt, bc_dt_vld, stallb, bc_ps_err,
        output bc_dm_req, bc_dm_we, bc_dm_addr, bc_dm_wdt
    );

    modport slave (
        output ps_bc_rd, ps_bc_wr, ps_bc_imm, ps_bc_addr, ps_bc_imm_dt, ps_bc_err_clr,
        output xb_dtx, dm_bc_ack, dm_bc_rdt,
        input  bc_dt, bc_dt_vld, stallb, bc_ps_err,
        input  bc_dm_req, bc_dm_we, bc_dm_addr, bc_dm_wdt
    );
endinterface

// File: rtl/bc_dm_bridge.sv
// Bus-connect stage: loads and immediates into the CU write-back path, stores
// out to data memory through a one-entry posted buffer, with a DM ack timeout.
module bc_dm_bridge #(
    parameter int DATA_WIDTH    = 16,
    parameter int DM_ADDR_WIDTH = 16,
    parameter int TIMEOUT       = 15
) (
    input logic            clk_exe,
    input logic            reset,
    bc_dm_bridge_if.master bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ST_DRAIN = 2'd1,
        RD_WAIT  = 2'd2
    } state_t;

    // Abandon on the edge that completes the TIMEOUT-th unacknowledged request cycle.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t                   state_reg;
    logic [7:0]               tmo_cnt_reg;
    logic [DATA_WIDTH-1:0]    dt_reg;
    logic                     dt_vld_reg;
    logic                     err_reg;
    logic                     req_reg;
    logic                     we_reg;
    logic [DM_ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0]    wdt_reg;

    logic buf_full;
    logic stall;
    logic acc_rd;
    logic acc_wr;
    logic acc_imm;

    // The store buffer is full exactly while its write owns the DM bus.
    always_comb begin
        buf_full = (state_reg == ST_DRAIN);
        stall    = (state_reg == RD_WAIT) || (buf_full && (bus.ps_bc_rd || bus.ps_bc_wr));
        acc_rd   = bus.ps_bc_rd && !stall;
        acc_wr   = !bus.ps_bc_rd && bus.ps_bc_wr && !stall;
        acc_imm  = !bus.ps_bc_rd && !bus.ps_bc_wr && bus.ps_bc_imm && !stall;
    end

    always_ff @(posedge clk_exe or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            tmo_cnt_reg <= 8'd0;
            dt_reg      <= '0;
            dt_vld_reg  <= 1'b0;
            err_reg     <= 1'b0;
            req_reg     <= 1'b0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdt_reg     <= '0;
        end else begin
            dt_vld_reg <= 1'b0;
            if (bus.ps_bc_err_clr) begin
                err_reg <= 1'b0;
            end
            if (acc_imm) begin
                dt_reg     <= bus.ps_bc_imm_dt;
                dt_vld_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (acc_rd) begin
                        req_reg     <= 1'b1;
                        we_reg      <= 1'b0;
                        addr_reg    <= bus.ps_bc_addr;
                        tmo_cnt_reg <= 8'd0;
                        state_reg   <= RD_WAIT;
                    end else if (acc_wr) begin
                        req_reg     <= 1'b1;
                        we_reg      <= 1'b1;
                        addr_reg    <= bus.ps_bc_addr;
                        wdt_reg     <= bus.xb_dtx;
                        tmo_cnt_reg <= 8'd0;
                        state_reg   <= ST_DRAIN;
                    end
                end
                ST_DRAIN, RD_WAIT: begin
                    if (bus.dm_bc_ack) begin
                        req_reg     <= 1'b0;
                        we_reg      <= 1'b0;
                        tmo_cnt_reg <= 8'd0;
                        state_reg   <= IDLE;
                        if (state_reg == RD_WAIT) begin
                            dt_reg     <= bus.dm_bc_rdt;
                            dt_vld_reg <= 1'b1;
                        end
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        // Abandoned load still completes toward the CU, with zero data.
                        req_reg     <= 1'b0;
                        we_reg      <= 1'b0;
                        tmo_cnt_reg <= 8'd0;
                        err_reg     <= 1'b1;
                        state_reg   <= IDLE;
                        if (state_reg == RD_WAIT) begin
                            dt_reg     <= '0;
                            dt_vld_reg <= 1'b1;
                        end
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    req_reg   <= 1'b0;
                    we_reg    <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.stallb     = !stall;
    assign bus.bc_dt      = dt_reg;
    assign bus.bc_dt_vld  = dt_vld_reg;
    assign bus.bc_ps_err  = err_reg;
    assign bus.bc_dm_req  = req_reg;
    assign bus.bc_dm_we   = we_reg;
    assign bus.bc_dm_addr = addr_reg;
    assign bus.bc_dm_wdt  = wdt_reg;
endmodule

// File: tb/tb_bc_dm_bridge.sv
// Bench for bc_dm_bridge: directed scenarios with literal expectations, then
// randomized PS/DM traffic checked each cycle against a transaction-level model.
module tb_bc_dm_bridge;
    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int TMO = 15;

    logic clk_exe = 1'b0;
    logic reset;
    always #5 clk_exe = ~clk_exe;

    bc_dm_bridge_if #(.DATA_WIDTH(DW), .DM_ADDR_WIDTH(AW)) bus ();

    bc_dm_bridge #(.DATA_WIDTH(DW), .DM_ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
        .clk_exe (clk_exe),
        .reset   (reset),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model state: one outstanding DM transaction at most, plus CU-facing results.
    bit          m_busy, m_load, m_vld, m_err, m_acc;
    logic [15:0] m_addr, m_wdt, m_dt;
    int          m_wait;
    logic [15:0] m_mem [16];

    // Data-memory responder.
    logic [15:0] dm_mem [16];
    int          dm_mode, dm_ws, dm_pct, dm_cnt;
    logic        st_req, st_we;
    logic [15:0] st_addr, st_wdt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_load = 0; m_vld = 0; m_err = 0; m_acc = 0; m_wait = 0;
        m_dt = '0;
    endtask

    task automatic model_step();
        bit stall, set_err, any;
        stall   = m_busy && (m_load || bus.ps_bc_rd || bus.ps_bc_wr);
        any     = bus.ps_bc_rd || bus.ps_bc_wr || bus.ps_bc_imm;
        m_acc   = any && !stall;
        m_vld   = 0;
        set_err = 0;
        if (m_busy) begin
            if (bus.dm_bc_ack) begin
                if (m_load) begin
                    m_dt  = m_mem[m_addr[3:0]];
                    m_vld = 1;
                end else begin
                    m_mem[m_addr[3:0]] = m_wdt;
                end
                m_busy = 0;
            end else begin
                m_wait++;
                if (m_wait == TMO) begin
                    set_err = 1;
                    m_busy  = 0;
                    if (m_load) begin
                        m_dt  = '0;
                        m_vld = 1;
                    end
                end
            end
        end
        if (!stall) begin
            if (bus.ps_bc_rd) begin
                m_busy = 1; m_load = 1; m_addr = bus.ps_bc_addr; m_wait = 0;
            end else if (bus.ps_bc_wr) begin
                m_busy = 1; m_load = 0; m_addr = bus.ps_bc_addr; m_wdt = bus.xb_dtx; m_wait = 0;
            end else if (bus.ps_bc_imm) begin
                m_dt  = bus.ps_bc_imm_dt;
                m_vld = 1;
            end
        end
        if (set_err) m_err = 1;
        else if (bus.ps_bc_err_clr) m_err = 0;
    endtask

    task automatic compare();
        logic exp_stallb;
        exp_stallb = !(m_busy && (m_load || bus.ps_bc_rd || bus.ps_bc_wr));
        chk("stallb", bus.stallb, exp_stallb);
        chk("bc_dt", bus.bc_dt, m_dt);
        chk("bc_dt_vld", bus.bc_dt_vld, m_vld);
        chk("bc_ps_err", bus.bc_ps_err, m_err);
        chk("bc_dm_req", bus.bc_dm_req, m_busy);
        if (m_busy) begin
            chk("bc_dm_we", bus.bc_dm_we, !m_load);
            chk("bc_dm_addr", bus.bc_dm_addr, m_addr);
            if (!m_load) chk("bc_dm_wdt", bus.bc_dm_wdt, m_wdt);
        end
    endtask

    task automatic dm_drive();
        logic ack;
        if (bus.bc_dm_req) begin
            if (dm_mode == 0) ack = (dm_cnt == dm_ws);
            else              ack = ($urandom_range(0, 99) < dm_pct);
            dm_cnt = ack ? 0 : dm_cnt + 1;
        end else begin
            dm_cnt = 0;
            ack    = (dm_mode == 1) && ($urandom_range(0, 99) < 20);
        end
        bus.dm_bc_ack = ack;
        bus.dm_bc_rdt = (ack && bus.bc_dm_req && !bus.bc_dm_we) ? dm_mem[bus.bc_dm_addr[3:0]]
                                                                : 16'($urandom);
    endtask

    // One clock: check at negedge, advance model at posedge, drive DM 1 time unit later.
    task automatic cycle();
        @(negedge clk_exe);
        compare();
        st_req  = bus.bc_dm_req;
        st_we   = bus.bc_dm_we;
        st_addr = bus.bc_dm_addr;
        st_wdt  = bus.bc_dm_wdt;
        @(posedge clk_exe);
        if (!reset) model_reset();
        else        model_step();
        if (reset && bus.dm_bc_ack && st_req && st_we) dm_mem[st_addr[3:0]] = st_wdt;
        #1;
        dm_drive();
    endtask

    // kind: 0 load, 1 store, 2 immediate; held until the model sees it accepted.
    task automatic issue(input int kind, input logic [15:0] a, input logic [15:0] d, output int ncyc);
        bus.ps_bc_rd     = (kind == 0);
        bus.ps_bc_wr     = (kind == 1);
        bus.ps_bc_imm    = (kind == 2);
        bus.ps_bc_addr   = a;
        bus.xb_dtx       = d;
        bus.ps_bc_imm_dt = d;
        ncyc = 0;
        do begin
            cycle();
            ncyc++;
        end while (!m_acc && ncyc < 60);
        chk("issue_accept", m_acc, 1);
        bus.ps_bc_rd  = 0;
        bus.ps_bc_wr  = 0;
        bus.ps_bc_imm = 0;
    endtask

    task automatic wait_vld();
        int n;
        n = 0;
        while (!bus.bc_dt_vld && n < 60) begin
            cycle();
            n++;
        end
        chk("vld_wait", bus.bc_dt_vld, 1);
    endtask

    task automatic drive_random();
        bit pending;
        pending = bus.ps_bc_rd || bus.ps_bc_wr || bus.ps_bc_imm;
        if (!(pending && !m_acc)) begin
            bus.ps_bc_rd     = ($urandom_range(0, 99) < 20);
            bus.ps_bc_wr     = ($urandom_range(0, 99) < 30);
            bus.ps_bc_imm    = ($urandom_range(0, 99) < 30);
            bus.ps_bc_addr   = 16'h0040 + 16'($urandom_range(0, 15));
            bus.xb_dtx       = 16'($urandom);
            bus.ps_bc_imm_dt = 16'($urandom);
        end
        bus.ps_bc_err_clr = ($urandom_range(0, 99) < 10);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        bus.ps_bc_rd = 0; bus.ps_bc_wr = 0; bus.ps_bc_imm = 0; bus.ps_bc_err_clr = 0;
        bus.ps_bc_addr = '0; bus.ps_bc_imm_dt = '0; bus.xb_dtx = '0;
        bus.dm_bc_ack = 0; bus.dm_bc_rdt = '0;
        for (int i = 0; i < 16; i++) begin
            m_mem[i]  = 16'(i * 257);
            dm_mem[i] = 16'(i * 257);
        end
        model_reset();
        dm_mode = 0; dm_ws = 0; dm_pct = 0; dm_cnt = 0;

        repeat (3) cycle();
        chk("rst_stallb", bus.stallb, 1);
        chk("rst_req", bus.bc_dm_req, 0);
        chk("rst_dt", bus.bc_dt, 0);
        chk("rst_vld", bus.bc_dt_vld, 0);
        chk("rst_err", bus.bc_ps_err, 0);
        reset = 1'b1;
        cycle();

        // Immediate transfer
        issue(2, 16'h0000, 16'h1234, n);
        chk("imm_nostall", n, 1);
        chk("imm_dt", bus.bc_dt, 16'h1234);
        chk("imm_vld", bus.bc_dt_vld, 1);
        cycle();
        chk("imm_pulse", bus.bc_dt_vld, 0);

        // Posted store, two DM wait states
        dm_ws = 2;
        issue(1, 16'h0040, 16'hBEEF, n);
        chk("st_nostall", n, 1);
        n = 0;
        while (bus.bc_dm_req && n < 20) begin
            chk("st_we", bus.bc_dm_we, 1);
            chk("st_addr", bus.bc_dm_addr, 16'h0040);
            chk("st_wdt", bus.bc_dm_wdt, 16'hBEEF);
            n++;
            cycle();
        end
        chk("st_req_cycles", n, 3);

        // Back-to-back stores, DM latency 3
        dm_ws = 3;
        issue(1, 16'h0041, 16'h1111, n);
        issue(1, 16'h0040, 16'h2222, n);
        chk("b2b_accept_cycles", n, 5);
        chk("b2b_req", bus.bc_dm_req, 1);
        chk("b2b_addr", bus.bc_dm_addr, 16'h0040);

        // Store then load of the same word: load must see the store
        issue(1, 16'h0040, 16'hBEEF, n);
        issue(0, 16'h0040, 16'h0000, n);
        wait_vld();
        chk("ld_after_st", bus.bc_dt, 16'hBEEF);

        // Zero-wait DM: vld two edges after accept
        dm_ws = 0;
        issue(0, 16'h0041, 16'h0000, n);
        cycle();
        chk("zw_vld", bus.bc_dt_vld, 1);
        chk("zw_dt", bus.bc_dt, 16'h1111);

        // DM never acks: abandoned load
        dm_ws = -1;
        issue(0, 16'h0042, 16'h0000, n);
        n = 0;
        while (bus.bc_dm_req && n < 40) begin
            n++;
            cycle();
        end
        chk("tmo_req_cycles", n, TMO);
        chk("tmo_dt", bus.bc_dt, 0);
        chk("tmo_vld", bus.bc_dt_vld, 1);
        chk("tmo_err", bus.bc_ps_err, 1);
        bus.ps_bc_err_clr = 1;
        cycle();
        bus.ps_bc_err_clr = 0;
        chk("err_clr", bus.bc_ps_err, 0);

        // Asynchronous reset in the middle of a load
        issue(0, 16'h0043, 16'h0000, n);
        cycle();
        cycle();
        reset = 1'b0;
        #2;
        chk("arst_req", bus.bc_dm_req, 0);
        chk("arst_stallb", bus.stallb, 1);
        model_reset();
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        dm_ws = 1;
        issue(0, 16'h0041, 16'h0000, n);
        wait_vld();
        chk("post_rst_dt", bus.bc_dt, 16'h1111);

        // Randomized traffic with varying DM responsiveness
        dm_mode = 1;
        for (int ph = 0; ph < 6; ph++) begin
            dm_pct = (ph % 3 == 0) ? 60 : (ph % 3 == 1) ? 30 : 5;
            repeat (500) begin
                cycle();
                drive_random();
            end
        end
        bus.ps_bc_rd = 0; bus.ps_bc_wr = 0; bus.ps_bc_imm = 0; bus.ps_bc_err_clr = 0;
        repeat (40) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
